imm_gen_pipe: RTL and testbench

- Pipelined, parametrised successor to the decode-stage immediate generator.
- Takes one 32-bit instruction per cycle on a valid/ready handshake and produces an XLEN-wide immediate, a format code and an illegal-opcode flag.
- Has a registered output stage and a 2-entry skid buffer, so it sits between fetch/IF-ID and the decode/register-read stage without combinational ready paths.
- Adds RV64 support, CSR zimm, JALR/OP-IMM-32 decode, tag pass-through and backpressure handling.

---
 rtl/imm_gen_pipe.sv | 172 +++++++++++++++++
 tb/tb_imm_gen_pipe.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator: decode, registered output, one skid slot.
// in_ready comes straight from a flop, so out_ready never reaches it.
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag
);

  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $error("imm_gen_pipe: XLEN must be 32 or 64");
  end

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_Z    = 3'd6,
    FMT_RSV  = 3'd7
  } fmt_e;

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    fmt_e             fmt;
    logic             ill;
    logic [TAG_W-1:0] tag;
  } pay_t;

  localparam bit RV64 = (XLEN == 64);

  logic [6:0] w_opc;
  logic       w_op_i;
  logic       w_op_iw;
  logic       w_op_s;
  logic       w_op_b;
  logic       w_op_u;
  logic       w_op_j;
  logic       w_op_sys;
  logic       w_op_r;
  logic       w_op_rw;
  pay_t       w_dec;

  assign w_opc    = in_instr[6:0];
  assign w_op_i   = (w_opc == 7'b0010011) ||
                    (w_opc == 7'b0000011) ||
                    (w_opc == 7'b1100111);
  assign w_op_iw  = (w_opc == 7'b0011011);
  assign w_op_s   = (w_opc == 7'b0100011);
  assign w_op_b   = (w_opc == 7'b1100011);
  assign w_op_u   = (w_opc == 7'b0110111) ||
                    (w_opc == 7'b0010111);
  assign w_op_j   = (w_opc == 7'b1101111);
  assign w_op_sys = (w_opc == 7'b1110011);
  assign w_op_r   = (w_opc == 7'b0110011) ||
                    (w_opc == 7'b0001111);
  assign w_op_rw  = (w_opc == 7'b0111011);

  always_comb begin
    w_dec     = '0;
    w_dec.tag = in_tag;
    unique case (1'b1)
      w_op_i: begin
        w_dec.fmt = FMT_I;
        w_dec.imm = XLEN'($signed(in_instr[31:20]));
      end
      w_op_iw: begin
        if (RV64) begin
          w_dec.fmt = FMT_I;
          w_dec.imm = XLEN'($signed(in_instr[31:20]));
        end else begin
          w_dec.ill = 1'b1;
        end
      end
      w_op_s: begin
        w_dec.fmt = FMT_S;
        w_dec.imm = XLEN'($signed({in_instr[31:25],
                                   in_instr[11:7]}));
      end
      w_op_b: begin
        w_dec.fmt = FMT_B;
        w_dec.imm = XLEN'($signed({in_instr[31],
                                   in_instr[7],
                                   in_instr[30:25],
                                   in_instr[11:8],
                                   1'b0}));
      end
      w_op_u: begin
        w_dec.fmt = FMT_U;
        w_dec.imm = XLEN'($signed({in_instr[31:12],
                                   12'b0}));
      end
      w_op_j: begin
        w_dec.fmt = FMT_J;
        w_dec.imm = XLEN'($signed({in_instr[31],
                                   in_instr[19:12],
                                   in_instr[20],
                                   in_instr[30:21],
                                   1'b0}));
      end
      w_op_sys: begin
        // funct3[2] selects the zimm CSR forms
        if (in_instr[14]) begin
          w_dec.fmt = FMT_Z;
          w_dec.imm = XLEN'(in_instr[19:15]);
        end
      end
      w_op_r: begin
        w_dec.fmt = FMT_NONE;
      end
      w_op_rw: begin
        w_dec.ill = !RV64;
      end
      default: begin
        w_dec.ill = 1'b1;
      end
    endcase
  end

  logic r_ov;
  logic r_sfull;
  pay_t r_out;
  pay_t r_skid;
  logic w_acc;

  assign w_acc    = in_valid && !r_sfull;
  assign in_ready = !r_sfull;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ov    <= 1'b0;
      r_sfull <= 1'b0;
      r_out   <= '0;
      r_skid  <= '0;
    end else if (r_sfull) begin
      if (out_ready) begin
        r_out   <= r_skid;
        r_sfull <= 1'b0;
      end
    end else if (w_acc) begin
      if (!r_ov || out_ready) begin
        r_out <= w_dec;
        r_ov  <= 1'b1;
      end else begin
        r_skid  <= w_dec;
        r_sfull <= 1'b1;
      end
    end else if (out_ready) begin
      r_ov <= 1'b0;
    end
  end

  assign out_valid   = r_ov;
  assign out_imm     = r_out.imm;
  assign out_fmt     = r_out.fmt;
  assign out_illegal = r_out.ill;
  assign out_tag     = r_out.tag;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: decode table on XLEN=32 and XLEN=64 instances,
// then backpressure, alternating ready and mid-stream reset sequences.
module tb_imm_gen_pipe;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [7:0]  in_tag;
  logic        out_ready;

  logic        in_ready32;
  logic        out_valid32;
  logic [31:0] out_imm32;
  logic [2:0]  out_fmt32;
  logic        out_ill32;
  logic [7:0]  out_tag32;

  logic        in_ready64;
  logic        out_valid64;
  logic [63:0] out_imm64;
  logic [2:0]  out_fmt64;
  logic        out_ill64;
  logic [7:0]  out_tag64;

  imm_gen_pipe #(.XLEN(32), .TAG_W(8)) u32 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready32),
    .in_instr(in_instr), .in_tag(in_tag),
    .out_valid(out_valid32), .out_ready(out_ready),
    .out_imm(out_imm32), .out_fmt(out_fmt32),
    .out_illegal(out_ill32), .out_tag(out_tag32)
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(8)) u64 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready64),
    .in_instr(in_instr), .in_tag(in_tag),
    .out_valid(out_valid64), .out_ready(out_ready),
    .out_imm(out_imm64), .out_fmt(out_fmt64),
    .out_illegal(out_ill64), .out_tag(out_tag64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [63:0] imm64;
    logic [2:0]  fmt64;
    logic        ill64;
    logic [31:0] imm32;
    logic [2:0]  fmt32;
    logic        ill32;
  } vec_t;

  vec_t vecs[$];
  int   errors = 0;
  int   checks = 0;
  logic [7:0] sb[$];
  logic [7:0] ntag;
  int   rcv;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic add(input logic [31:0] ins,
                     input logic [63:0] i64, input logic [2:0] f64,
                     input logic l64,
                     input logic [31:0] i32, input logic [2:0] f32,
                     input logic l32);
    vec_t v;
    v.instr = ins;
    v.imm64 = i64; v.fmt64 = f64; v.ill64 = l64;
    v.imm32 = i32; v.fmt32 = f32; v.ill32 = l32;
    vecs.push_back(v);
  endtask

  // One handshake cycle on the XLEN=32 instance with a tag scoreboard.
  task automatic cyc(input bit v, input bit r, input bit bub);
    logic pre;
    logic [7:0] e;
    @(negedge clk);
    pre       = in_ready32;
    in_valid  = v;
    in_tag    = ntag;
    in_instr  = {4'h0, ntag, 20'h00093};
    out_ready = r;
    #1;
    chk("ready_indep", {63'd0, in_ready32}, {63'd0, pre});
    if (bub && r) chk("no_bubble", {63'd0, out_valid32}, 64'd1);
    if (out_valid32 && r) begin
      if (sb.size() == 0) begin
        chk("sb_extra", {56'd0, out_tag32}, 64'hFFFF);
      end else begin
        e = sb.pop_front();
        chk("sb_tag", {56'd0, out_tag32}, {56'd0, e});
        chk("sb_imm", {32'd0, out_imm32}, {56'd0, e});
        rcv++;
      end
    end
    if (v && in_ready32) begin
      sb.push_back(ntag);
      ntag++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (sb.size() != 0 && g < 20) begin
      cyc(1'b0, 1'b1, 1'b0);
      g++;
    end
    chk("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  task automatic stall_chk(input string nm);
    chk({nm, "_rdy"}, {63'd0, in_ready32}, 64'd0);
    chk({nm, "_vld"}, {63'd0, out_valid32}, 64'd1);
    chk({nm, "_tag"}, {56'd0, out_tag32}, 64'd2);
    chk({nm, "_imm"}, {32'd0, out_imm32}, 64'd2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int g;
    vec_t v;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_instr  = '0;
    in_tag    = '0;
    out_ready = 1'b1;
    ntag      = '0;
    rcv       = 0;

    add(32'hFFF00093, 64'hFFFFFFFFFFFFFFFF, 3'd1, 0, 32'hFFFFFFFF, 3'd1, 0);
    add(32'hFE000EE3, 64'hFFFFFFFFFFFFFFFC, 3'd3, 0, 32'hFFFFFFFC, 3'd3, 0);
    add(32'h300FD073, 64'h1F,               3'd6, 0, 32'h1F,       3'd6, 0);
    add(32'h800002B7, 64'hFFFFFFFF80000000, 3'd4, 0, 32'h80000000, 3'd4, 0);
    add(32'hFFF0009B, 64'hFFFFFFFFFFFFFFFF, 3'd1, 0, 32'h0,        3'd0, 1);
    add(32'h00000000, 64'h0,                3'd0, 1, 32'h0,        3'd0, 1);
    add(32'hFFFFFFFF, 64'h0,                3'd0, 1, 32'h0,        3'd0, 1);
    add(32'hFE20AC23, 64'hFFFFFFFFFFFFFFF8, 3'd2, 0, 32'hFFFFFFF8, 3'd2, 0);
    add(32'h0080006F, 64'h8,                3'd5, 0, 32'h8,        3'd5, 0);
    add(32'h8000006F, 64'hFFFFFFFFFFF00000, 3'd5, 0, 32'hFFF00000, 3'd5, 0);
    add(32'h00000033, 64'h0,                3'd0, 0, 32'h0,        3'd0, 0);
    add(32'h0000003B, 64'h0,                3'd0, 0, 32'h0,        3'd0, 1);
    add(32'h30001073, 64'h0,                3'd0, 0, 32'h0,        3'd0, 0);
    add(32'h80002083, 64'hFFFFFFFFFFFFF800, 3'd1, 0, 32'hFFFFF800, 3'd1, 0);
    add(32'h7FF08067, 64'h7FF,              3'd1, 0, 32'h7FF,      3'd1, 0);
    add(32'h0000000F, 64'h0,                3'd0, 0, 32'h0,        3'd0, 0);
    add(32'h12345297, 64'h12345000,         3'd4, 0, 32'h12345000, 3'd4, 0);

    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_vld32", {63'd0, out_valid32}, 64'd0);
    chk("rst_vld64", {63'd0, out_valid64}, 64'd0);
    chk("rst_rdy32", {63'd0, in_ready32}, 64'd1);
    chk("rst_rdy64", {63'd0, in_ready64}, 64'd1);
    chk("rst_imm32", {32'd0, out_imm32}, 64'd0);
    chk("rst_imm64", out_imm64, 64'd0);
    chk("rst_fmt", {61'd0, out_fmt32}, 64'd0);
    chk("rst_ill", {63'd0, out_ill32}, 64'd0);
    chk("rst_tag", {56'd0, out_tag32}, 64'd0);

    // Back-to-back decode, result one cycle after each accept.
    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      @(negedge clk);
      in_valid  = 1'b1;
      in_instr  = v.instr;
      in_tag    = 8'(i + 8'h40);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("t_vld32", {63'd0, out_valid32}, 64'd1);
      chk("t_imm32", {32'd0, out_imm32}, {32'd0, v.imm32});
      chk("t_fmt32", {61'd0, out_fmt32}, {61'd0, v.fmt32});
      chk("t_ill32", {63'd0, out_ill32}, {63'd0, v.ill32});
      chk("t_tag32", {56'd0, out_tag32}, 64'(i + 8'h40));
      chk("t_vld64", {63'd0, out_valid64}, 64'd1);
      chk("t_imm64", out_imm64, v.imm64);
      chk("t_fmt64", {61'd0, out_fmt64}, {61'd0, v.fmt64});
      chk("t_ill64", {63'd0, out_ill64}, {63'd0, v.ill64});
      chk("t_tag64", {56'd0, out_tag64}, 64'(i + 8'h40));
    end
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("empty_vld32", {63'd0, out_valid32}, 64'd0);
    chk("empty_vld64", {63'd0, out_valid64}, 64'd0);

    // Backpressure: three stalled cycles while tags 1..6 stream.
    ntag = 8'd1;
    rcv  = 0;
    sb.delete();
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    chk("bp_rdy_one", {63'd0, in_ready32}, 64'd1);
    cyc(1'b1, 1'b0, 1'b0);
    stall_chk("bp_s1");
    cyc(1'b1, 1'b0, 1'b0);
    stall_chk("bp_s2");
    cyc(1'b1, 1'b0, 1'b0);
    stall_chk("bp_s3");
    g = 0;
    while (ntag <= 8'd6 && g < 30) begin
      cyc(1'b1, 1'b1, 1'b0);
      g++;
    end
    drain();
    chk("bp_count", 64'(rcv), 64'd6);

    // Alternating out_ready with continuous input.
    ntag = 8'd7;
    rcv  = 0;
    for (int k = 0; k < 16; k++) begin
      cyc(1'b1, (k % 2) == 0, k > 0);
    end
    chk("alt_accepts", 64'(ntag - 8'd7), 64'd9);
    drain();
    chk("alt_count", 64'(rcv), 64'd9);

    // Reset with the skid slot full.
    ntag = 8'h80;
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    chk("rs_full_rdy", {63'd0, in_ready32}, 64'd0);
    chk("rs_full_vld", {63'd0, out_valid32}, 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rs_async_vld32", {63'd0, out_valid32}, 64'd0);
    chk("rs_async_vld64", {63'd0, out_valid64}, 64'd0);
    chk("rs_async_rdy", {63'd0, in_ready32}, 64'd1);
    chk("rs_async_tag", {56'd0, out_tag32}, 64'd0);
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    sb.delete();
    rcv  = 0;
    ntag = 8'h90;
    cyc(1'b1, 1'b1, 1'b0);
    chk("rs_post_vld", {63'd0, out_valid32}, 64'd1);
    chk("rs_post_tag", {56'd0, out_tag32}, 64'h90);
    drain();
    chk("rs_post_cnt", 64'(rcv), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
